// File: rtl/gray_pkg.sv
// gray_pkg: shared mode encodings and width-generic binary/Gray conversion functions.
// Callers zero-extend to MAX_W and truncate back to their own width.
package gray_pkg;
   localparam logic MODE_B2G = 1'b0;
   localparam logic MODE_G2B = 1'b1;
   localparam int MAX_W = 32;
   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
      logic [MAX_W-1:0] g;
      g[MAX_W-1] = b[MAX_W-1];
      for (int i = MAX_W - 2; i >= 0; i--) g[i] = b[i+1] ^ b[i];
      return g;
   endfunction
   // Zero upper bits stay zero through the prefix XOR, so narrower words convert correctly.
   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
      logic [MAX_W-1:0] b;
      b[MAX_W-1] = g[MAX_W-1];
      for (int i = MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
endpackage

// File: rtl/gray_adj_checker.sv
// gray_adj_checker: flags any accepted G2B word that is not a single-bit step from the previous one.
// History is dropped by reset and by any B2G transfer; the flag is sticky until reset.
module gray_adj_checker
   import gray_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_fire,
   input  logic         in_mode,
   input  logic [W-1:0] in_data,
   output logic         adj_err
);
   logic [W-1:0] hist_q, hist_d;
   logic         hist_vld_q, hist_vld_d;
   logic         err_q, err_d;
   logic         g2b_fire;
   always_comb begin
      g2b_fire   = in_fire & (in_mode == MODE_G2B);
      hist_d     = g2b_fire ? in_data : hist_q;
      hist_vld_d = in_fire ? g2b_fire : hist_vld_q;
      err_d      = err_q | (g2b_fire & hist_vld_q & ($countones(in_data ^ hist_q) != 1));
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist_q     <= '0;
         hist_vld_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         hist_q     <= hist_d;
         hist_vld_q <= hist_vld_d;
         err_q      <= err_d;
      end
   end
   assign adj_err = err_q;
endmodule

// File: rtl/gray_codec_stream.sv
// gray_codec_stream: registered binary<->Gray converter with a valid/ready stream on each side.
// Define GRAY_ADJ_CHECK_EN to add the sticky adjacency checker on the G2B stream.
module gray_codec_stream
   import gray_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         in_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_mode,
   output logic         adj_err
);
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_data_q, out_data_d;
   logic         out_mode_q, out_mode_d;
   logic         in_fire;
   logic [W-1:0] conv;
   // Single output register: accept whenever it is empty or draining this cycle.
   always_comb begin
      in_ready    = ~out_valid_q | out_ready;
      in_fire     = in_valid & in_ready;
      conv        = (in_mode == MODE_G2B) ? W'(gray2bin(MAX_W'(in_data)))
                                          : W'(bin2gray(MAX_W'(in_data)));
      out_valid_d = in_fire | (out_valid_q & ~out_ready);
      out_data_d  = in_fire ? conv : out_data_q;
      out_mode_d  = in_fire ? in_mode : out_mode_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_mode_q  <= MODE_B2G;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_mode_q  <= out_mode_d;
      end
   end
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_mode  = out_mode_q;
`ifdef GRAY_ADJ_CHECK_EN
   gray_adj_checker #(.W(W)) u_adj (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_fire (in_fire),
      .in_mode (in_mode),
      .in_data (in_data),
      .adj_err (adj_err)
   );
`else
   assign adj_err = 1'b0;
`endif
endmodule
